// File: rtl/usb_rx_ram_writer.sv
// Packs a USB RX byte stream into 32-bit words in a ring-buffer RAM and commits whole packets.
// Optional feature macro: RX_PKT_HDR_EN reserves a header word per packet holding {8'hA5, 8'h00, length}.
module usb_rx_ram_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_eop,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] head_ptr,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_bytes,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_DROP    = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
`ifdef RX_PKT_HDR_EN
  localparam logic [2:0] S_HDR     = 3'd4;
`endif

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] head_ptr_q, head_ptr_d;
  logic [ADDR_W-1:0] pkt_start_q, pkt_start_d;
  logic [1:0]        lane_q, lane_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rx_ready_q, rx_ready_d;
  logic              pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0]  pkt_bytes_q, pkt_bytes_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_writedata_q, ram_writedata_d;
  logic [BE_W-1:0]   ram_byteenable_q, ram_byteenable_d;
  logic              ram_write_q, ram_write_d;

  logic              accept, start, take, hdr_full, word_done, full;
  logic [ADDR_W-1:0] rd_last, data_ptr, ptr_c;
  logic [1:0]        lane_c;
  logic [DATA_W-1:0] asm_c, merged;
  logic [BE_W-1:0]   be_c, be_merged;
  logic [LEN_W-1:0]  count_inc;

  assign accept  = rx_valid & rx_ready_q;
  assign start   = accept && (state_q == S_IDLE);
  assign rd_last = rd_ptr - ADDR_W'(1);

`ifdef RX_PKT_HDR_EN
  assign data_ptr = wr_ptr_q + ADDR_W'(1);
  assign hdr_full = (wr_ptr_q == rd_last);
`else
  assign data_ptr = wr_ptr_q;
  assign hdr_full = 1'b0;
`endif

  // The first byte of a packet starts from an empty assembly word.
  assign take      = accept && ((state_q == S_COLLECT) || (start && !hdr_full));
  assign lane_c    = start ? 2'd0 : lane_q;
  assign asm_c     = start ? '0 : asm_q;
  assign be_c      = start ? '0 : be_q;
  assign ptr_c     = start ? data_ptr : wr_ptr_q;
  assign merged    = asm_c | (DATA_W'(rx_data) << {lane_c, 3'b000});
  assign be_merged = be_c | (BE_W'(1) << lane_c);
  assign word_done = take && ((lane_c == 2'd3) || rx_eop);
  assign full      = word_done && (ptr_c == rd_last);
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + LEN_W'(1);

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    head_ptr_d       = head_ptr_q;
    pkt_start_d      = pkt_start_q;
    lane_d           = lane_q;
    count_d          = count_q;
    asm_d            = asm_q;
    be_d             = be_q;
    rx_ready_d       = 1'b1;
    pkt_done_d       = 1'b0;
    pkt_bytes_d      = pkt_bytes_q;
    overflow_d       = ovf_clr ? 1'b0 : overflow_q;
    ram_address_d    = '0;
    ram_writedata_d  = '0;
    ram_byteenable_d = '0;
    ram_write_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pkt_start_d = wr_ptr_q;
          if (hdr_full) begin
            overflow_d = 1'b1;
            state_d    = rx_eop ? S_IDLE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (accept && rx_eop) state_d = S_IDLE;
      end
`ifdef RX_PKT_HDR_EN
      S_HDR: begin
        ram_address_d    = pkt_start_q;
        ram_writedata_d  = {8'hA5, 8'h00, 16'(count_q)};
        ram_byteenable_d = 4'hF;
        ram_write_d      = 1'b1;
        state_d          = S_COMMIT;
      end
`endif
      S_COMMIT: begin
        head_ptr_d  = wr_ptr_q;
        pkt_bytes_d = count_q;
        pkt_done_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: ;
    endcase

    // Byte joins the packet: assemble, write a completed word, or drop on full.
    if (take) begin
      count_d = start ? LEN_W'(1) : count_inc;
      if (full) begin
        wr_ptr_d   = start ? wr_ptr_q : pkt_start_q;
        overflow_d = 1'b1;
        asm_d      = '0;
        be_d       = '0;
        lane_d     = 2'd0;
        state_d    = rx_eop ? S_IDLE : S_DROP;
      end else if (word_done) begin
        ram_address_d    = ptr_c;
        ram_writedata_d  = merged;
        ram_byteenable_d = be_merged;
        ram_write_d      = 1'b1;
        wr_ptr_d         = ptr_c + ADDR_W'(1);
        asm_d            = '0;
        be_d             = '0;
        lane_d           = 2'd0;
        rx_ready_d       = 1'b0;
`ifdef RX_PKT_HDR_EN
        state_d          = rx_eop ? S_HDR : S_COLLECT;
`else
        state_d          = rx_eop ? S_COMMIT : S_COLLECT;
`endif
      end else begin
        asm_d    = merged;
        be_d     = be_merged;
        lane_d   = lane_c + 2'd1;
        wr_ptr_d = ptr_c;
        state_d  = S_COLLECT;
      end
    end

`ifdef RX_PKT_HDR_EN
    if (state_d == S_HDR) rx_ready_d = 1'b0;
`endif
    if (state_d == S_COMMIT) rx_ready_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      head_ptr_q       <= '0;
      pkt_start_q      <= '0;
      lane_q           <= '0;
      count_q          <= '0;
      asm_q            <= '0;
      be_q             <= '0;
      rx_ready_q       <= 1'b0;
      pkt_done_q       <= 1'b0;
      pkt_bytes_q      <= '0;
      overflow_q       <= 1'b0;
      ram_address_q    <= '0;
      ram_writedata_q  <= '0;
      ram_byteenable_q <= '0;
      ram_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      head_ptr_q       <= head_ptr_d;
      pkt_start_q      <= pkt_start_d;
      lane_q           <= lane_d;
      count_q          <= count_d;
      asm_q            <= asm_d;
      be_q             <= be_d;
      rx_ready_q       <= rx_ready_d;
      pkt_done_q       <= pkt_done_d;
      pkt_bytes_q      <= pkt_bytes_d;
      overflow_q       <= overflow_d;
      ram_address_q    <= ram_address_d;
      ram_writedata_q  <= ram_writedata_d;
      ram_byteenable_q <= ram_byteenable_d;
      ram_write_q      <= ram_write_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign head_ptr       = head_ptr_q;
  assign pkt_done       = pkt_done_q;
  assign pkt_bytes      = pkt_bytes_q;
  assign overflow       = overflow_q;
  assign ram_address    = ram_address_q;
  assign ram_writedata  = ram_writedata_q;
  assign ram_byteenable = ram_byteenable_q;
  assign ram_write      = ram_write_q;
  assign ram_chipselect = ram_write_q;
  assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_usb_rx_ram_writer.sv
// Bench for usb_rx_ram_writer: packet-level ring model predicts RAM writes, commits and overflow.
module tb_usb_rx_ram_writer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_eop;
  logic              rx_ready;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] head_ptr;
  logic              pkt_done;
  logic [LEN_W-1:0]  pkt_bytes;
  logic              overflow;
  logic              ovf_clr;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic              ram_clken;

  usb_rx_ram_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_eop(rx_eop),
    .rx_ready(rx_ready), .rd_ptr(rd_ptr), .head_ptr(head_ptr), .pkt_done(pkt_done),
    .pkt_bytes(pkt_bytes), .overflow(overflow), .ovf_clr(ovf_clr),
    .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_be[$];
  logic [7:0]  cmt_head[$];
  logic [15:0] cmt_bytes[$];
  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];

  logic [7:0] m_wr, m_head;
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Per-cycle compare against the predicted write and commit streams.
  always @(negedge clk) begin
    if (!reset) begin
      check("cs_clken", {30'b0, ram_chipselect, ram_clken}, {30'b0, ram_write, 1'b1});
      if (ram_write) begin
        log_addr.push_back(ram_address);
        log_data.push_back(ram_writedata);
        log_be.push_back(ram_byteenable);
        if (exp_addr.size() == 0) begin
          fail("unexpected_write", $sformatf("got write addr %h want none", ram_address));
        end else begin
          check("wr_addr", 32'(ram_address), 32'(exp_addr.pop_front()));
          check("wr_data", ram_writedata, exp_data.pop_front());
          check("wr_be", 32'(ram_byteenable), 32'(exp_be.pop_front()));
        end
      end
      if (pkt_done) begin
        done_cnt++;
        if (cmt_head.size() == 0) begin
          fail("unexpected_commit", $sformatf("got pkt_done head %h want none", head_ptr));
        end else begin
          check("commit_head", 32'(head_ptr), 32'(cmt_head.pop_front()));
          check("commit_bytes", 32'(pkt_bytes), 32'(cmt_bytes.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit eop);
    int guard;
    guard = 0;
    rx_data  = d;
    rx_valid = 1'b1;
    rx_eop   = eop;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) fail("rx_ready_timeout", "got rx_ready 0 want 1");
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {27'b0, rx_ready, pkt_done, overflow, ram_write, ram_chipselect}, 32'h0);
    check("rst_ptrs", {head_ptr, pkt_bytes, ram_address}, 32'h0);
    check("rst_data", ram_writedata, 32'h0);
    check("rst_be_clken", {27'b0, ram_byteenable, ram_clken}, 32'h1);
    reset = 1'b0;
    m_wr = '0;
    m_head = '0;
    m_ovf = 1'b0;
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    cmt_head.delete(); cmt_bytes.delete();
  endtask

  // Model: a packet of W words fits only if the free ring space (one slot kept empty) covers it.
  task automatic run_pkt(input int n, input bit incr);
    logic [7:0]  b[];
    logic [31:0] d;
    logic [7:0]  base;
    int words, free, nfit, k;
    bit ok;
    b = new[n];
    for (int i = 0; i < n; i++) b[i] = incr ? 8'(i + 1) : 8'($urandom);
    words = (n + 3) / 4;
    free  = (int'(rd_ptr) - int'(m_wr) - 1 + 512) % 256;
`ifdef RX_PKT_HDR_EN
    ok   = (words + 1 <= free);
    nfit = ok ? words : ((free == 0) ? 0 : free - 1);
    base = m_wr + 8'd1;
`else
    ok   = (words <= free);
    nfit = ok ? words : free;
    base = m_wr;
`endif
    for (int w = 0; w < nfit; w++) begin
      d = '0;
      k = (n - 4 * w > 4) ? 4 : n - 4 * w;
      for (int j = 0; j < k; j++) d[8*j +: 8] = b[4*w + j];
      exp_addr.push_back(base + 8'(w));
      exp_data.push_back(d);
      exp_be.push_back(4'((1 << k) - 1));
    end
    if (ok) begin
`ifdef RX_PKT_HDR_EN
      exp_addr.push_back(m_wr);
      exp_data.push_back({8'hA5, 8'h00, 16'(n)});
      exp_be.push_back(4'hF);
      m_head = m_wr + 8'(words + 1);
`else
      m_head = m_wr + 8'(words);
`endif
      cmt_head.push_back(m_head);
      cmt_bytes.push_back(16'(n));
      m_wr = m_head;
    end else begin
      m_ovf = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(b[i], i == n - 1);
    end
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    repeat (6) @(negedge clk);
    check("pending_writes", 32'(exp_addr.size()), 32'd0);
    check("pending_commits", 32'(cmt_head.size()), 32'd0);
    check("idle_head", 32'(head_ptr), 32'(m_head));
    check("idle_overflow", 32'(overflow), 32'(m_ovf));
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    cmt_head.delete(); cmt_bytes.delete();
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    int base, dc;
    int diff;
    rx_data = '0; rx_valid = 1'b0; rx_eop = 1'b0; rd_ptr = '0; ovf_clr = 1'b0;
    @(negedge clk);
    do_reset();

`ifdef RX_PKT_HDR_EN
    // 6-byte packet: data at 1..2, header at 0
    run_pkt(6, 1'b1);
    check("t6_a1", {log_addr[0], log_be[0]}, {8'd1, 4'hF});
    check("t6_d1", log_data[0], 32'h04030201);
    check("t6_a2", {log_addr[1], log_be[1]}, {8'd2, 4'h3});
    check("t6_hdr", {24'b0, log_addr[2]}, 32'd0);
    check("t6_hdr_d", log_data[2], 32'hA5000006);
    check("t6_head", 32'(head_ptr), 32'd3);
`else
    run_pkt(8, 1'b1);
    check("t1_w0", {log_addr[0], log_be[0]}, {8'd0, 4'hF});
    check("t1_d0", log_data[0], 32'h04030201);
    check("t1_w1", {log_addr[1], log_be[1]}, {8'd1, 4'hF});
    check("t1_d1", log_data[1], 32'h08070605);
    check("t1_head", {head_ptr, pkt_bytes}, {8'd2, 16'd8});
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    run_pkt(5, 1'b1);
    check("t2_w2", {log_addr[2], log_be[2]}, {8'd2, 4'hF});
    check("t2_w3", {log_addr[3], log_be[3]}, {8'd3, 4'h1});
    check("t2_d3", log_data[3], 32'h00000005);
    check("t2_head", {head_ptr, pkt_bytes}, {8'd4, 16'd5});
`endif

    // Overflow: ring of 255 usable words cannot hold 1100 bytes
    do_reset();
    dc = done_cnt;
    run_pkt(1100, 1'b0);
    check("t3_ovf", {31'b0, overflow}, 32'd1);
    check("t3_head", 32'(head_ptr), 32'd0);
    check("t3_no_done", 32'(done_cnt), 32'(dc));
    run_pkt(4, 1'b0);
    check("t3_restart_addr", {24'b0, log_addr[log_addr.size() - 1]}, 32'd0);
    pulse_clr();

    // Wrap-around
    do_reset();
    run_pkt(1016, 1'b0);
    rd_ptr = 8'd10;
    base = log_addr.size();
    run_pkt(12, 1'b1);
`ifndef RX_PKT_HDR_EN
    check("t4_addrs", {8'b0, log_addr[base], log_addr[base+1], log_addr[base+2]}, {8'b0, 8'd254, 8'd255, 8'd0});
    check("t4_head", 32'(head_ptr), 32'd1);
`endif

    // Reset mid-packet after 3 bytes
    rd_ptr = 8'd0;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h10), 1'b0);
    do_reset();
    base = log_addr.size();
    run_pkt(4, 1'b0);
`ifdef RX_PKT_HDR_EN
    check("t5_addr", {24'b0, log_addr[base]}, 32'd1);
`else
    check("t5_addr", {24'b0, log_addr[base]}, 32'd0);
`endif

    // Random traffic with a CPU consumer moving rd_ptr between packets
    for (int p = 0; p < 60; p++) begin
      diff = (int'(m_head) - int'(rd_ptr) + 256) % 256;
      rd_ptr = rd_ptr + 8'($urandom_range(0, diff));
      if ($urandom_range(0, 3) == 0) pulse_clr();
      if ($urandom_range(0, 7) == 0) run_pkt($urandom_range(300, 1100), 1'b0);
      else run_pkt($urandom_range(1, 40), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
